// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing and test-pattern generator.
// All outputs are registered from the pre-edge (hc,vc) and advance only on pix_en edges.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int H_FP       = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BP       = 88,
  parameter int V_ACTIVE   = 600,
  parameter int V_FP       = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BP       = 23,
  parameter bit HS_POL     = 1'b1,
  parameter bit VS_POL     = 1'b1,
  parameter int CNT_W      = 11,
  parameter int COLOR_W    = 1,
  parameter int CHECK_LOG2 = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pix_en,
  input  logic [1:0]         mode,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               frame_start,
  output logic               line_start,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W_RAW = H_ACTIVE / 8;
  localparam int BAR_W     = (BAR_W_RAW < 1) ? 1 : BAR_W_RAW;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
  localparam logic [COLOR_W-1:0] ONE    = {COLOR_W{1'b1}};

  logic [CNT_W-1:0]   hc, vc, hc_n, vc_n;
  logic [CNT_W-1:0]   bar_cnt, bar_cnt_n;
  logic [2:0]         bar_idx, bar_idx_n;
  logic [1:0]         mode_q, cur_mode;
  logic               origin, de_n, hs_act, vs_act, checker_white;
  logic [COLOR_W-1:0] r_n, g_n, b_n;

  always_comb begin
    hc_n      = hc + 1'b1;
    vc_n      = vc;
    bar_cnt_n = bar_cnt + 1'b1;
    bar_idx_n = bar_idx;
    if (hc == H_LAST) begin
      hc_n      = '0;
      vc_n      = (vc == V_LAST) ? '0 : vc + 1'b1;
      bar_cnt_n = '0;
      bar_idx_n = '0;
    end else if (bar_cnt == BAR_LAST) begin
      // Bar index steps every BAR_W pixels and parks on the last bar.
      bar_cnt_n = '0;
      bar_idx_n = (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
    end
  end

  always_comb begin
    origin        = (hc == '0) && (vc == '0);
    // The mode sampled at pixel (0,0) already applies to that pixel.
    cur_mode      = origin ? mode : mode_q;
    de_n          = (hc < H_ACT) && (vc < V_ACT);
    hs_act        = (hc >= HS_BEG) && (hc < HS_END);
    vs_act        = (vc >= VS_BEG) && (vc < VS_END);
    checker_white = ~(hc[CHECK_LOG2] ^ vc[CHECK_LOG2]);
    r_n = ONE;
    g_n = ONE;
    b_n = ONE;
    case (cur_mode)
      2'd1: begin
        r_n = {COLOR_W{~bar_idx[1]}};
        g_n = {COLOR_W{~bar_idx[2]}};
        b_n = {COLOR_W{~bar_idx[0]}};
      end
      2'd2: begin
        r_n = {COLOR_W{checker_white}};
        g_n = {COLOR_W{checker_white}};
        b_n = {COLOR_W{checker_white}};
      end
      2'd3: begin
        r_n = hc[COLOR_W-1:0];
        g_n = hc[COLOR_W-1:0];
        b_n = hc[COLOR_W-1:0];
      end
      default: ;
    endcase
    if (!de_n) begin
      r_n = '0;
      g_n = '0;
      b_n = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      bar_cnt     <= '0;
      bar_idx     <= '0;
      mode_q      <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else if (pix_en) begin
      hc          <= hc_n;
      vc          <= vc_n;
      bar_cnt     <= bar_cnt_n;
      bar_idx     <= bar_idx_n;
      if (origin) mode_q <= mode;
      hs          <= hs_act ? HS_POL : ~HS_POL;
      vs          <= vs_act ? VS_POL : ~VS_POL;
      de          <= de_n;
      x           <= hc;
      y           <= vc;
      frame_start <= origin;
      line_start  <= (hc == '0);
      r           <= r_n;
      g           <= g_n;
      b           <= b_n;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a small 24x12 raster (H 16/2/4/2, V 8/1/2/1).
// Expected values are hand-computed from the raster geometry.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int CNT_W   = 11;
  localparam int COLOR_W = 2;
  localparam int H_TOT   = 24;
  localparam int FRAME   = 24 * 12;
  localparam int NVEC    = 21;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               pix_en = 1'b0;
  logic [1:0]         mode = 2'd0;
  logic               hs, vs, de, frame_start, line_start;
  logic [CNT_W-1:0]   x, y;
  logic [COLOR_W-1:0] r, g, b;
  logic [5:0]         rgb;

  assign rgb = {r, g, b};

  always #5 clock = ~clock;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .CNT_W(CNT_W),
    .COLOR_W(COLOR_W), .CHECK_LOG2(2)
  ) dut (
    .clock(clock), .reset(reset), .pix_en(pix_en), .mode(mode),
    .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
    .frame_start(frame_start), .line_start(line_start),
    .r(r), .g(g), .b(b)
  );

  typedef struct {
    int         edge_n;
    int         ex;
    int         ey;
    bit         ede, ehs, evs, efs, els;
    logic [5:0] ergb;
  } vec_t;

  vec_t             tbl [NVEC];
  int               checks = 0;
  int               failures = 0;
  int               pix = -1;
  logic [CNT_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; outputs are sampled 1ns after the rising edge.
  task automatic tick(input bit en);
    pix_en = en;
    @(posedge clock);
    #1;
    if (en) pix = (pix + 1) % FRAME;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pix_en = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    pix   = -1;
  endtask

  task automatic step_to(input int target);
    int n = 0;
    while (pix != target && n < 2 * FRAME) begin
      tick(1'b1);
      n++;
    end
    if (pix != target) check("step_to_timeout", pix, target);
  endtask

  task automatic check_pix(input string tag, input int ex, input int ey, input logic [5:0] ergb);
    check({tag, "_x"}, 32'(x), ex);
    check({tag, "_y"}, 32'(y), ey);
    check({tag, "_rgb"}, 32'(rgb), 32'(ergb));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hs"}, 32'(hs), 1);
    check({tag, "_vs"}, 32'(vs), 0);
    check({tag, "_de"}, 32'(de), 0);
    check({tag, "_x"}, 32'(x), 0);
    check({tag, "_y"}, 32'(y), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_ls"}, 32'(line_start), 0);
    check({tag, "_rgb"}, 32'(rgb), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // edge, x, y, de, hs, vs, fs, ls, rgb   (mode 1 colour bars, BAR_W = 2)
    tbl[0]  = '{1,   0,  0, 1, 1, 0, 1, 1, 6'b111111};
    tbl[1]  = '{3,   2,  0, 1, 1, 0, 0, 0, 6'b111100};
    tbl[2]  = '{5,   4,  0, 1, 1, 0, 0, 0, 6'b001111};
    tbl[3]  = '{7,   6,  0, 1, 1, 0, 0, 0, 6'b001100};
    tbl[4]  = '{9,   8,  0, 1, 1, 0, 0, 0, 6'b110011};
    tbl[5]  = '{11, 10,  0, 1, 1, 0, 0, 0, 6'b110000};
    tbl[6]  = '{13, 12,  0, 1, 1, 0, 0, 0, 6'b000011};
    tbl[7]  = '{15, 14,  0, 1, 1, 0, 0, 0, 6'b000000};
    tbl[8]  = '{16, 15,  0, 1, 1, 0, 0, 0, 6'b000000};
    tbl[9]  = '{17, 16,  0, 0, 1, 0, 0, 0, 6'b000000};
    tbl[10] = '{18, 17,  0, 0, 1, 0, 0, 0, 6'b000000};
    tbl[11] = '{19, 18,  0, 0, 0, 0, 0, 0, 6'b000000};
    tbl[12] = '{22, 21,  0, 0, 0, 0, 0, 0, 6'b000000};
    tbl[13] = '{23, 22,  0, 0, 1, 0, 0, 0, 6'b000000};
    tbl[14] = '{25,  0,  1, 1, 1, 0, 0, 1, 6'b111111};
    tbl[15] = '{171, 2,  7, 1, 1, 0, 0, 0, 6'b111100};
    tbl[16] = '{193, 0,  8, 0, 1, 0, 0, 1, 6'b000000};
    tbl[17] = '{217, 0,  9, 0, 1, 1, 0, 1, 6'b000000};
    tbl[18] = '{264, 23, 10, 0, 1, 1, 0, 0, 6'b000000};
    tbl[19] = '{265, 0, 11, 0, 1, 0, 0, 1, 6'b000000};
    tbl[20] = '{289, 0,  0, 1, 1, 0, 1, 1, 6'b111111};

    // Reset state.
    reset = 1'b1;
    #12;
    check_reset_vals("reset");

    // Full frame plus wrap with colour bars held from reset.
    mode = 2'd1;
    do_reset();
    begin
      int ti = 0;
      for (int e = 1; e <= 290 && ti < NVEC; e++) begin
        tick(1'b1);
        if (tbl[ti].edge_n == e) begin
          check("tbl_x",   32'(x),           tbl[ti].ex);
          check("tbl_y",   32'(y),           tbl[ti].ey);
          check("tbl_de",  32'(de),          32'(tbl[ti].ede));
          check("tbl_hs",  32'(hs),          32'(tbl[ti].ehs));
          check("tbl_vs",  32'(vs),          32'(tbl[ti].evs));
          check("tbl_fs",  32'(frame_start), 32'(tbl[ti].efs));
          check("tbl_ls",  32'(line_start),  32'(tbl[ti].els));
          check("tbl_rgb", 32'(rgb),         32'(tbl[ti].ergb));
          ti++;
        end
      end
      check("tbl_all_applied", ti, NVEC);
    end

    // pix_en one clock in four: outputs hold between enables, line is 24 enables.
    mode = 2'd0;
    do_reset();
    for (int e = 0; e <= H_TOT; e++) begin
      tick(1'b1);
      exp_q.push_back(CNT_W'(e % H_TOT));
      for (int k = 0; k < 4; k++) begin
        check("slow_x", 32'(x), 32'(exp_q[0]));
        check("slow_hs", 32'(hs), (exp_q[0] >= 18 && exp_q[0] <= 21) ? 0 : 1);
        check("slow_ls", 32'(line_start), (exp_q[0] == 0) ? 1 : 0);
        if (k < 3) tick(1'b0);
      end
      void'(exp_q.pop_front());
    end
    check("slow_y_next_line", 32'(y), 1);

    // Mid-frame switch 0 -> 2 waits for the next frame, then 2 -> 3 likewise.
    mode = 2'd0;
    do_reset();
    step_to(4 * H_TOT + 2);
    check_pix("m0_pre", 2, 4, 6'b111111);
    mode = 2'd2;
    step_to(6 * H_TOT + 0);
    check_pix("m0_hold_a", 0, 6, 6'b111111);
    step_to(6 * H_TOT + 8);
    check_pix("m0_hold_b", 8, 6, 6'b111111);
    step_to(0);
    check("m2_fs", 32'(frame_start), 1);
    check_pix("m2_0_0", 0, 0, 6'b111111);
    step_to(4);
    check_pix("m2_4_0", 4, 0, 6'b000000);
    step_to(4 * H_TOT + 0);
    check_pix("m2_0_4", 0, 4, 6'b000000);
    step_to(4 * H_TOT + 4);
    check_pix("m2_4_4", 4, 4, 6'b111111);
    mode = 2'd3;
    step_to(5 * H_TOT + 1);
    check_pix("m2_hold", 1, 5, 6'b000000);
    step_to(2);
    check_pix("m3_2_0", 2, 0, 6'b101010);
    tick(1'b1);
    check_pix("m3_3_0", 3, 0, 6'b111111);
    step_to(5);
    check_pix("m3_5_0", 5, 0, 6'b010101);
    step_to(H_TOT + 17);
    check_pix("m3_blank", 17, 1, 6'b000000);

    // Asynchronous reset mid-frame, then restart from (0,0) with bars.
    mode = 2'd1;
    do_reset();
    step_to(5 * H_TOT + 10);
    check_pix("pre_rst", 10, 5, 6'b110000);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    pix   = -1;
    tick(1'b1);
    check("rst_fs", 32'(frame_start), 1);
    check("rst_ls", 32'(line_start), 1);
    check("rst_de", 32'(de), 1);
    check_pix("rst_p0", 0, 0, 6'b111111);
    tick(1'b1);
    check_pix("rst_p1", 1, 0, 6'b111111);
    tick(1'b1);
    check_pix("rst_p2", 2, 0, 6'b111100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
